// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the wide SRAM pattern generator.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_FETCH = 2'd1,
    PG_HOLD  = 2'd2,
    PG_DONE  = 2'd3
  } pg_state_e;

  localparam int PG_MAX_BEATS = 4;
  localparam int PG_BEAT_W    = 2;

  // A step must be long enough to prefetch every beat of the next word.
  function automatic logic [31:0] pg_period(input logic [31:0] ts, input logic [31:0] beats);
    return ((ts + 32'd1) > (beats + 32'd1)) ? (ts + 32'd1) : (beats + 32'd1);
  endfunction

endpackage

// File: rtl/pg_beat_fetch.sv
// Reads BEATS consecutive SRAM bytes per request into a shadow word, wrapping end->start.
module pg_beat_fetch
  import pattern_gen_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int BEATS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clr,
  input  logic                 req,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [ADDR_W-1:0]    end_addr,
  input  logic [7:0]           sram_data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 word_valid,
  output logic                 word_last,
  output logic [8*BEATS-1:0]   word
);

  logic [ADDR_W-1:0]       start_q, end_q;
  logic [PG_BEAT_W-1:0]    beat;
  logic                    busy;
  logic [BEATS-1:0][7:0]   shadow;
  logic                    at_end;

  assign at_end = (addr == end_q);
  assign word   = shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      start_q    <= '0;
      end_q      <= '0;
      beat       <= '0;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        addr      <= '0;
        beat      <= '0;
        busy      <= 1'b0;
        word_last <= 1'b0;
      end else if (load) begin
        start_q   <= start_addr;
        end_q     <= end_addr;
        addr      <= start_addr;
        beat      <= '0;
        busy      <= 1'b1;
        word_last <= 1'b0;
      end else begin
        // Data for the address driven this cycle is captured at this edge.
        if (busy) begin
          addr <= at_end ? start_q : addr + ADDR_W'(1);
          beat <= beat + PG_BEAT_W'(1);
          if (beat == PG_BEAT_W'(BEATS - 1)) begin
            busy       <= 1'b0;
            word_valid <= 1'b1;
            word_last  <= at_end;
          end
        end
        if (req) begin
          busy <= 1'b1;
          beat <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (busy && !clr && !load) begin
      for (int i = 0; i < BEATS; i++)
        if (beat == PG_BEAT_W'(i)) shadow[i] <= sram_data;
    end
  end

endmodule

// File: rtl/pattern_gen_wide.sv
// Streams an SRAM pattern as BEATS-byte GPIO words with prescale, repeat, abort and config checks.
module pattern_gen_wide
  import pattern_gen_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int BEATS  = 2,
  parameter int GPIO_W = 8 * BEATS,
  parameter int TS_W   = 16,
  parameter int REP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [ADDR_W-1:0] cfg_end_addr,
  input  logic [TS_W-1:0]   cfg_timestep,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic [7:0]        sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              pattern_active,
  output logic              pattern_done,
  output logic              cfg_err,
  output logic [GPIO_W-1:0] gpio_out
);

  pg_state_e         state;
  logic [TS_W:0]     cnt;
  logic [REP_W-1:0]  pass_cnt, pass_inc;
  logic [TS_W-1:0]   ts_q;
  logic [REP_W-1:0]  rep_q;
  logic              final_q;

  logic [ADDR_W:0]   span;
  logic              cfg_ok, accept, abort, cnt_last, last_now, fetch_req;
  logic [31:0]       period;
  logic              word_valid, word_last;
  logic [GPIO_W-1:0] word;

  assign span   = {1'b0, cfg_end_addr} - {1'b0, cfg_start_addr} + (ADDR_W+1)'(1);
  assign cfg_ok = (cfg_start_addr <= cfg_end_addr) && ((span % (ADDR_W+1)'(BEATS)) == '0);
  assign abort  = stop && (state != PG_IDLE);
  assign accept = (state == PG_IDLE) && start && !stop && cfg_ok;

  assign period   = pg_period(32'(ts_q), 32'(BEATS));
  assign cnt_last = (32'(cnt) == (period - 32'd1));
  assign pass_inc = pass_cnt + REP_W'(1);
  // The word about to be shown closes the final pass; nothing further to prefetch.
  assign last_now = word_last && (rep_q != '0) && (pass_inc == rep_q);

  assign fetch_req = !abort && !last_now &&
                     (((state == PG_FETCH) && word_valid) ||
                      ((state == PG_HOLD) && cnt_last && !final_q));

  pg_beat_fetch #(.ADDR_W(ADDR_W), .BEATS(BEATS)) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .clr        (abort),
    .req        (fetch_req),
    .start_addr (cfg_start_addr),
    .end_addr   (cfg_end_addr),
    .sram_data  (sram_data),
    .addr       (sram_addr),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= PG_IDLE;
      cnt            <= '0;
      pass_cnt       <= '0;
      ts_q           <= '0;
      rep_q          <= '0;
      final_q        <= 1'b0;
      gpio_out       <= '0;
      pattern_active <= 1'b0;
      pattern_done   <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      pattern_done <= 1'b0;
      cfg_err      <= 1'b0;
      if (abort) begin
        state          <= PG_IDLE;
        pattern_active <= 1'b0;
        gpio_out       <= '0;
        final_q        <= 1'b0;
      end else begin
        case (state)
          PG_IDLE: begin
            if (start && !stop) begin
              if (cfg_ok) begin
                ts_q           <= cfg_timestep;
                rep_q          <= cfg_repeat;
                pass_cnt       <= '0;
                final_q        <= 1'b0;
                pattern_active <= 1'b1;
                state          <= PG_FETCH;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          PG_FETCH: begin
            if (word_valid) begin
              gpio_out <= word;
              cnt      <= '0;
              final_q  <= last_now;
              state    <= PG_HOLD;
              if (word_last) pass_cnt <= pass_inc;
            end
          end
          PG_HOLD: begin
            if (cnt_last) begin
              if (final_q) begin
                state          <= PG_DONE;
                pattern_done   <= 1'b1;
                pattern_active <= 1'b0;
              end else begin
                gpio_out <= word;
                cnt      <= '0;
                final_q  <= last_now;
                if (word_last) pass_cnt <= pass_inc;
              end
            end else begin
              cnt <= cnt + (TS_W+1)'(1);
            end
          end
          PG_DONE: state <= PG_IDLE;
          default: state <= PG_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen_wide.sv
// Scoreboard bench: stimulus queues timed events, a negedge monitor matches DUT output changes.
module tb_pattern_gen_wide;

  localparam int ADDR_W = 19;
  localparam int BEATS  = 2;
  localparam int GPIO_W = 16;
  localparam int TS_W   = 16;
  localparam int REP_W  = 8;

  localparam int K_GPIO = 0;
  localparam int K_ACT  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] cfg_start_addr = '0;
  logic [ADDR_W-1:0] cfg_end_addr = '0;
  logic [TS_W-1:0]   cfg_timestep = '0;
  logic [REP_W-1:0]  cfg_repeat = '0;
  logic [7:0]        sram_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              pattern_active, pattern_done, cfg_err;
  logic [GPIO_W-1:0] gpio_out;

  logic [7:0] mem [0:255];
  assign sram_data = (sram_addr < ADDR_W'(256)) ? mem[sram_addr[7:0]] : 8'h00;

  pattern_gen_wide #(
    .ADDR_W(ADDR_W), .BEATS(BEATS), .GPIO_W(GPIO_W), .TS_W(TS_W), .REP_W(REP_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .cfg_start_addr (cfg_start_addr),
    .cfg_end_addr   (cfg_end_addr),
    .cfg_timestep   (cfg_timestep),
    .cfg_repeat     (cfg_repeat),
    .sram_data      (sram_data),
    .sram_addr      (sram_addr),
    .pattern_active (pattern_active),
    .pattern_done   (pattern_done),
    .cfg_err        (cfg_err),
    .gpio_out       (gpio_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                kind;
    int                cyc;
    logic [GPIO_W-1:0] data;
  } ev_t;
  ev_t exq[$];

  function automatic string kname(input int k);
    case (k)
      K_GPIO:  return "gpio_out";
      K_ACT:   return "pattern_active";
      K_DONE:  return "pattern_done";
      default: return "cfg_err";
    endcase
  endfunction

  task automatic exp_ev(input int kind, input int c, input logic [GPIO_W-1:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.data = d;
    exq.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [GPIO_W-1:0] d);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s at cyc %0d: got %h, required no event", kname(kind), cyc, d);
    end else begin
      e = exq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data != d)
        begin
          errors++;
          $display("FAIL event: got %s=%h at cyc %0d, required %s=%h at cyc %0d",
                   kname(kind), d, cyc, kname(e.kind), e.data, e.cyc);
        end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: every output change or pulse becomes an event matched in order.
  initial begin
    logic [GPIO_W-1:0] pg;
    logic pa;
    pg = '0; pa = 1'b0;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      if (gpio_out !== pg) observe(K_GPIO, gpio_out);
      if (pattern_active !== pa) observe(K_ACT, GPIO_W'(pattern_active));
      if (pattern_done === 1'b1) observe(K_DONE, GPIO_W'(1));
      if (cfg_err === 1'b1) observe(K_ERR, GPIO_W'(1));
      pg = gpio_out;
      pa = pattern_active;
    end
  end

  // Start is sampled at the following posedge (edge 0); cycle k then has cyc == t0 + k.
  task automatic go(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                    input logic [TS_W-1:0] ts, input logic [REP_W-1:0] rep, output int t0);
    @(negedge clk);
    cfg_start_addr = sa; cfg_end_addr = ea; cfg_timestep = ts; cfg_repeat = rep;
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic drop_start();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic basic_expect(input int t0);
    exp_ev(K_ACT,  t0 + 1,  16'h0001);
    exp_ev(K_GPIO, t0 + 4,  16'h2211);
    exp_ev(K_GPIO, t0 + 14, 16'h4433);
    exp_ev(K_ACT,  t0 + 24, 16'h0000);
    exp_ev(K_DONE, t0 + 24, 16'h0001);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;

    #23;
    chk("reset gpio_out", 32'(gpio_out), 32'h0);
    chk("reset pattern_active", 32'(pattern_active), 32'h0);
    chk("reset pattern_done", 32'(pattern_done), 32'h0);
    chk("reset cfg_err", 32'(cfg_err), 32'h0);
    chk("reset sram_addr", 32'(sram_addr), 32'h0);
    #4 rst_n = 1'b1;

    // Basic run, plus address sequencing of the first fetch.
    go(19'h10, 19'h13, 16'd9, 8'd1, t0);
    basic_expect(t0);
    drop_start();
    wait_cyc(t0 + 1);
    chk("first sram_addr", 32'(sram_addr), 32'h10);
    wait_cyc(t0 + 2);
    chk("second sram_addr", 32'(sram_addr), 32'h11);
    wait_cyc(t0 + 30);

    // Minimum period clamp: P = BEATS+1 = 3, two passes.
    go(19'h10, 19'h13, 16'd0, 8'd2, t0);
    exp_ev(K_ACT,  t0 + 1,  16'h0001);
    exp_ev(K_GPIO, t0 + 4,  16'h2211);
    exp_ev(K_GPIO, t0 + 7,  16'h4433);
    exp_ev(K_GPIO, t0 + 10, 16'h2211);
    exp_ev(K_GPIO, t0 + 13, 16'h4433);
    exp_ev(K_ACT,  t0 + 16, 16'h0000);
    exp_ev(K_DONE, t0 + 16, 16'h0001);
    drop_start();
    wait_cyc(t0 + 22);

    // Wrap: three passes at P = 5, start ignored while running.
    go(19'h10, 19'h13, 16'd4, 8'd3, t0);
    exp_ev(K_ACT, t0 + 1, 16'h0001);
    for (int p = 0; p < 3; p++) begin
      exp_ev(K_GPIO, t0 + 4 + 10*p, 16'h2211);
      exp_ev(K_GPIO, t0 + 9 + 10*p, 16'h4433);
    end
    exp_ev(K_ACT,  t0 + 34, 16'h0000);
    exp_ev(K_DONE, t0 + 34, 16'h0001);
    drop_start();
    wait_cyc(t0 + 6);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_cyc(t0 + 40);

    // Infinite repeat, stop mid-HOLD of the third word.
    go(19'h10, 19'h13, 16'd5, 8'd0, t0);
    exp_ev(K_ACT,  t0 + 1,  16'h0001);
    exp_ev(K_GPIO, t0 + 4,  16'h2211);
    exp_ev(K_GPIO, t0 + 10, 16'h4433);
    exp_ev(K_GPIO, t0 + 16, 16'h2211);
    exp_ev(K_GPIO, t0 + 19, 16'h0000);
    exp_ev(K_ACT,  t0 + 19, 16'h0000);
    drop_start();
    wait_cyc(t0 + 18);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_cyc(t0 + 30);

    // Config errors: start > end, then length not a multiple of BEATS.
    go(19'h20, 19'h10, 16'd3, 8'd1, t0);
    exp_ev(K_ERR, t0 + 1, 16'h0001);
    drop_start();
    wait_cyc(t0 + 5);
    go(19'h10, 19'h12, 16'd3, 8'd1, t0);
    exp_ev(K_ERR, t0 + 1, 16'h0001);
    drop_start();
    wait_cyc(t0 + 5);

    // Stop together with start in IDLE: nothing happens.
    go(19'h10, 19'h13, 16'd3, 8'd1, t0);
    stop = 1'b1;
    drop_start();
    stop = 1'b0;
    wait_cyc(t0 + 12);

    // Asynchronous reset during the second pass, then a clean restart.
    go(19'h10, 19'h13, 16'd4, 8'd3, t0);
    exp_ev(K_ACT,  t0 + 1,  16'h0001);
    exp_ev(K_GPIO, t0 + 4,  16'h2211);
    exp_ev(K_GPIO, t0 + 9,  16'h4433);
    exp_ev(K_GPIO, t0 + 14, 16'h2211);
    exp_ev(K_GPIO, t0 + 17, 16'h0000);
    exp_ev(K_ACT,  t0 + 17, 16'h0000);
    drop_start();
    wait_cyc(t0 + 16);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset gpio_out", 32'(gpio_out), 32'h0);
    chk("async reset pattern_active", 32'(pattern_active), 32'h0);
    chk("async reset sram_addr", 32'(sram_addr), 32'h0);
    chk("async reset pattern_done", 32'(pattern_done), 32'h0);
    wait_cyc(t0 + 20);
    #2 rst_n = 1'b1;

    go(19'h10, 19'h13, 16'd9, 8'd1, t0);
    basic_expect(t0);
    drop_start();
    wait_cyc(t0 + 32);

    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL pending events: got %0d unseen, required 0 (next %s at cyc %0d)",
               exq.size(), kname(exq[0].kind), exq[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
